// File: rtl/safe_code_entry_if.sv
`default_nettype none
// ============================================================================
//  Module   : safe_code_entry_if
//  Purpose  : Link between the safe front end and the combinational checker.
//             The front end presents a combination on S (qualified by
//             s_valid); the checker answers with reject (L0) / accept (L1).
//  Ports    : S[3:0]  combination under evaluation   (master -> slave)
//             s_valid S holds a fresh combination     (master -> slave)
//             L0      reject verdict                  (slave  -> master)
//             L1      accept verdict                  (slave  -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface safe_code_entry_if;
  logic [3:0] S;
  logic       s_valid;
  logic       L0;
  logic       L1;

  modport master (output S, output s_valid, input L0, input L1);
  modport slave  (input S, input s_valid, output L0, output L1);
endinterface
`default_nettype wire

// File: rtl/safe_code_entry.sv
`default_nettype none
// ============================================================================
//  Module   : safe_code_entry
//  Purpose  : Sequential front end of the digital safe. Debounces ENTER,
//             latches the key switches, presents them to the checker, samples
//             the verdict, counts consecutive failures, enforces a timed
//             lockout and keeps the safe open until relocked.
//  Ports    : clk       system clock (rising edge)
//             rst_n     asynchronous active-low reset
//             key_in    raw combination switches
//             enter_in  raw ENTER button (may bounce)
//             chk       checker link (S, s_valid out; L0, L1 in)
//             open      safe unlocked
//             alarm     lockout active
//             fail_cnt  consecutive failed attempts (saturates at MAX_FAIL)
//  Revision : 1.0  initial release
// ============================================================================
module safe_code_entry #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int MAX_FAIL     = 3,
  parameter int LOCKOUT_CYC  = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic [3:0]    key_in,
  input  wire logic          enter_in,
  safe_code_entry_if.master  chk,
  output logic               open,
  output logic               alarm,
  output logic [2:0]         fail_cnt
);

  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TMR_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  localparam logic [DB_W-1:0]  c_db_last    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0] c_tmr_load   = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [2:0]       c_fail_limit = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESENT = 3'd1,
    ST_EVAL    = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_enter_db;
  logic             r_db_prev;
  logic [DB_W-1:0]  r_db_cnt;
  logic [TMR_W-1:0] r_timer;
  logic             w_press;
  logic [2:0]       w_fail_inc;

  // --------------------------------------------------------------------------
  // ENTER synchronizer + debouncer. The debounced level only flips after a
  // run of DEBOUNCE_CYC synchronized samples that disagree with it; a single
  // agreeing sample restarts the run.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_enter_db <= 1'b0;
      r_db_prev  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1   <= enter_in;
      r_sync2   <= r_sync1;
      r_db_prev <= r_enter_db;
      if (r_sync2 != r_enter_db) begin
        if (r_db_cnt == c_db_last) begin
          r_enter_db <= r_sync2;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_press = r_enter_db & ~r_db_prev;

  // Failure count never wraps: once at the limit it stays there.
  assign w_fail_inc = (fail_cnt >= c_fail_limit) ? c_fail_limit : fail_cnt + 3'd1;

  // --------------------------------------------------------------------------
  // Attempt sequencer. All outputs are registered here, so the checker
  // verdict and the key switches never reach an output combinationally.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      chk.S       <= 4'd0;
      chk.s_valid <= 1'b0;
      open        <= 1'b0;
      alarm       <= 1'b0;
      fail_cnt    <= 3'd0;
      r_timer     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            chk.S       <= key_in;
            chk.s_valid <= 1'b1;
            r_state     <= ST_PRESENT;
          end
        end
        // One full cycle of settled S before the verdict is trusted.
        ST_PRESENT: r_state <= ST_EVAL;
        ST_EVAL: begin
          chk.s_valid <= 1'b0;
          // Only a clean accept opens; ambiguous verdicts count as failures.
          if (chk.L1 && !chk.L0) begin
            open     <= 1'b1;
            fail_cnt <= 3'd0;
            r_state  <= ST_OPEN;
          end else begin
            fail_cnt <= w_fail_inc;
            if (w_fail_inc == c_fail_limit) begin
              alarm   <= 1'b1;
              r_timer <= c_tmr_load;
              r_state <= ST_LOCKOUT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_OPEN: begin
          if (w_press) begin
            chk.S   <= 4'd0;
            open    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          // Timer loaded with LOCKOUT_CYC-1 so alarm spans LOCKOUT_CYC cycles.
          if (r_timer == '0) begin
            alarm    <= 1'b0;
            fail_cnt <= 3'd0;
            chk.S    <= 4'd0;
            r_state  <= ST_IDLE;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_safe_code_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_safe_code_entry
//  Purpose  : Self-checking bench for safe_code_entry. The stimulus side
//             predicts the sequence of distinct output snapshots each action
//             must produce (plus the spacing between some of them) and queues
//             them; a monitor pops one entry every time the outputs change.
//  Revision : 1.0  initial release
// ============================================================================
module tb_safe_code_entry;

  localparam int         DEB    = 4;
  localparam int         MAXF   = 3;
  localparam int         LOCK   = 16;
  localparam logic [3:0] SECRET = 4'b1110;

  typedef struct packed {
    logic [3:0] s;
    logic       sv;
    logic       op;
    logic       al;
    logic [2:0] fc;
  } snap_t;

  typedef struct packed {
    snap_t s;
    int    gap;   // required negedges since previous change, -1 = don't care
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key_in = 4'd0;
  logic       enter_in = 1'b0;
  logic       open;
  logic       alarm;
  logic [2:0] fail_cnt;
  int         mode = 0;  // 0 honest, 1 both high, 2 both low, 3 reject

  safe_code_entry_if chk_if ();

  safe_code_entry #(
    .DEBOUNCE_CYC (DEB),
    .MAX_FAIL     (MAXF),
    .LOCKOUT_CYC  (LOCK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .enter_in (enter_in),
    .chk      (chk_if),
    .open     (open),
    .alarm    (alarm),
    .fail_cnt (fail_cnt)
  );

  // Behavioural checker: the secret opens the safe in honest mode.
  assign chk_if.L1 = (mode == 0) ? (chk_if.S == SECRET) : (mode == 1);
  assign chk_if.L0 = (mode == 0) ? (chk_if.S != SECRET) : (mode == 1 || mode == 3);

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  snap_t m_cur = '0;
  int    m_fc = 0;
  bit    m_open = 1'b0;
  bit    mon_en = 1'b0;
  snap_t mon_prev = '0;
  int    gap_cnt = 0;

  function automatic snap_t mk(logic [3:0] s, logic sv, logic op, logic al, logic [2:0] fc);
    snap_t r;
    r.s = s; r.sv = sv; r.op = op; r.al = al; r.fc = fc;
    return r;
  endfunction

  function automatic snap_t sample_dut();
    return mk(chk_if.S, chk_if.s_valid, open, alarm, fail_cnt);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      snap_t now;
      exp_t  e;
      now = sample_dut();
      gap_cnt = gap_cnt + 1;
      if (now != mon_prev) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_change got S=%b sv=%b open=%b alarm=%b fc=%0d required no change",
                   now.s, now.sv, now.op, now.al, now.fc);
        end else begin
          e = exp_q.pop_front();
          if (now !== e.s) begin
            errors = errors + 1;
            $display("FAIL snapshot got S=%b sv=%b open=%b alarm=%b fc=%0d required S=%b sv=%b open=%b alarm=%b fc=%0d",
                     now.s, now.sv, now.op, now.al, now.fc, e.s.s, e.s.sv, e.s.op, e.s.al, e.s.fc);
          end
          if (e.gap >= 0) begin
            checks = checks + 1;
            if (gap_cnt != e.gap) begin
              errors = errors + 1;
              $display("FAIL spacing got %0d cycles required %0d", gap_cnt, e.gap);
            end
          end
        end
        mon_prev = now;
        gap_cnt  = 0;
      end
    end
  end

  // ---------------- reference model helpers ----------------
  task automatic push_exp(input snap_t s, input int gap);
    exp_t e;
    if (s != m_cur) begin
      e.s = s; e.gap = gap;
      exp_q.push_back(e);
      m_cur = s;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Key switches are scrambled after the latch point to prove S holds.
  task automatic enter_pulse(input bit bouncy, input logic [3:0] key);
    key_in = key;
    if (bouncy) begin
      for (int i = 0; i < 10; i++) begin
        enter_in = (i % 2 == 0);
        cyc(1);
      end
    end
    enter_in = 1'b1;
    cyc(7);
    key_in = 4'($urandom);
    cyc(1);
    enter_in = 1'b0;
    cyc(8);
  endtask

  task automatic glitch(input int len);
    enter_in = 1'b1;
    cyc(len);
    enter_in = 1'b0;
    cyc(10);
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks = checks + 1;
    if (got != req) begin
      errors = errors + 1;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_reset_outputs();
    check_val("rst_S", int'(chk_if.S), 0);
    check_val("rst_s_valid", int'(chk_if.s_valid), 0);
    check_val("rst_open", int'(open), 0);
    check_val("rst_alarm", int'(alarm), 0);
    check_val("rst_fail_cnt", int'(fail_cnt), 0);
  endtask

  task automatic do_reset();
    #2;
    push_exp(mk(4'd0, 1'b0, 1'b0, 1'b0, 3'd0), -1);
    m_fc = 0;
    m_open = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
  endtask

  task automatic relock(input bit bouncy);
    push_exp(mk(4'd0, 1'b0, 1'b0, 1'b0, 3'd0), -1);
    m_open = 1'b0;
    enter_pulse(bouncy, 4'($urandom));
  endtask

  // lock_act: 0 wait out lockout, 1 press during lockout, 2 reset mid-lockout
  task automatic attempt(input logic [3:0] key, input int md, input bit bouncy, input int lock_act);
    bit accepted;
    bit locked;
    mode = md;
    accepted = (md == 0) && (key == SECRET);
    locked = 1'b0;
    push_exp(mk(key, 1'b1, 1'b0, 1'b0, 3'(m_fc)), -1);
    if (accepted) begin
      m_fc = 0;
      m_open = 1'b1;
      push_exp(mk(key, 1'b0, 1'b1, 1'b0, 3'd0), 2);
    end else begin
      if (m_fc < MAXF) m_fc = m_fc + 1;
      if (m_fc == MAXF) begin
        locked = 1'b1;
        push_exp(mk(key, 1'b0, 1'b0, 1'b1, 3'(MAXF)), 2);
        if (lock_act != 2) begin
          m_fc = 0;
          push_exp(mk(4'd0, 1'b0, 1'b0, 1'b0, 3'd0), LOCK);
        end
      end else begin
        push_exp(mk(key, 1'b0, 1'b0, 1'b0, 3'(m_fc)), 2);
      end
    end
    enter_pulse(bouncy, key);
    if (locked) begin
      case (lock_act)
        1:       begin enter_pulse(1'b0, 4'($urandom)); cyc(4); end
        2:       do_reset();
        default: cyc(LOCK);
      endcase
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int md;
    #3 rst_n = 1'b0;
    cyc(3);
    check_reset_outputs();
    rst_n = 1'b1;
    cyc(2);
    mon_prev = sample_dut();
    mon_en = 1'b1;

    // Accept then relock.
    attempt(SECRET, 0, 1'b0, 0);
    relock(1'b0);
    // Three rejects -> lockout; press during lockout is ignored.
    attempt(4'b1100, 3, 1'b0, 0);
    attempt(4'b1100, 3, 1'b0, 0);
    attempt(4'b1100, 3, 1'b0, 1);
    // Ambiguous verdicts count as failures; accept clears the count.
    attempt(SECRET, 1, 1'b0, 0);
    attempt(SECRET, 2, 1'b0, 0);
    attempt(SECRET, 0, 1'b1, 0);
    // Reset while open.
    do_reset();
    // Reset during lockout.
    attempt(4'b0000, 3, 1'b0, 0);
    attempt(4'b0000, 3, 1'b0, 0);
    attempt(4'b0000, 3, 1'b0, 2);
    // Short glitches must not register as presses.
    glitch(3);
    glitch(1);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (m_open) begin
        if (r == 0) do_reset();
        else relock(r < 3);
      end else if (r == 9) begin
        glitch($urandom_range(1, 3));
      end else begin
        md = $urandom_range(0, 4);
        if (md > 3) md = 0;
        attempt(($urandom_range(0, 1) == 1) ? SECRET : 4'($urandom), md, r < 2,
                $urandom_range(0, 2));
      end
    end

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) cyc(1);
    check_val("queue_drained", exp_q.size(), 0);
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/safe_code_entry.md
# safe_code_entry

Sequential front end for the digital safe. It debounces the operator's ENTER button and latches the 4-bit combination from the key switches. It presents that combination to the combinational safe checker as `S`, then samples the checker's `L0`/`L1` verdict. It tracks consecutive failed attempts, enforces a timed lockout, and holds the safe open until the operator relocks it.

## Interface
- `DEBOUNCE_CYC`, default 4: consecutive identical samples needed before ENTER changes its debounced level (≥2).
- `MAX_FAIL`, default 3: consecutive rejected attempts that trigger lockout (1..7).
- `LOCKOUT_CYC`, default 16: lockout duration in clock cycles (≥1).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_in`  in  4  raw combination switches; sampled only at the accepted ENTER edge.
- `enter_in`  in  1  raw ENTER button, active high, may bounce.
- `L0`  in  1  checker verdict "reject" for the current `S`.
- `L1`  in  1  checker verdict "accept" for the current `S`.
- `S`  out  4  combination driven to the checker.
- `s_valid`  out  1  high while `S` holds a freshly entered combination under evaluation.
- `open`  out  1  safe unlocked.
- `alarm`  out  1  lockout active.
- `fail_cnt`  out  3  consecutive failed attempts.

## Operation
- Debouncer: `enter_in` passes through a 2-flop synchronizer. The debounced level `enter_db` toggles only after `DEBOUNCE_CYC` consecutive synchronized samples differ from the current `enter_db`. Any agreeing sample resets the run counter. `press` is a one-cycle pulse on each 0→1 edge of `enter_db`.
- States: IDLE, PRESENT, EVAL, OPEN, LOCKOUT.
- IDLE: on `press`, register `S <= key_in` and go to PRESENT. With no `press`, stay in IDLE.
- PRESENT: `s_valid`=1. Gives the checker one full cycle of settled `S`. Always go to EVAL.
- EVAL: `s_valid`=1. Sample `L0`/`L1` and decide:
  - `L1`=1, `L0`=0: go to OPEN and set `fail_cnt` to 0.
  - Any other combination, including both high or both low: counts as a failure and `fail_cnt` increments.
  - If the incremented `fail_cnt` equals `MAX_FAIL`, go to LOCKOUT and load the timer with `LOCKOUT_CYC`-1. Otherwise go to IDLE.
- OPEN: `open`=1 and `S` is held. On `press` (relock), clear `S` to 0 and go to IDLE.
- LOCKOUT: `alarm`=1. `press` is ignored. The timer decrements each cycle. When the timer reaches 0, go to IDLE next cycle, clear `fail_cnt` to 0, and clear `S` to 0.
- A `press` arriving in PRESENT or EVAL is discarded; presses are not queued.
- `fail_cnt` saturates at `MAX_FAIL` and never wraps.

## Timing
- Reset values: state=IDLE, `S`=0, `s_valid`=0, `open`=0, `alarm`=0, `fail_cnt`=0, debouncer cleared with `enter_db`=0, timer=0.
- Reset is asynchronous. Asserting `rst_n` in any state, including mid-lockout or OPEN, forces the reset values immediately. Operation restarts from IDLE on the first clock edge after release.
- Latency from a raw clean `enter_in` rise to `press`: 2 synchronizer cycles plus `DEBOUNCE_CYC` cycles.
- `press` to `S` update: 1 cycle (registered in the IDLE→PRESENT transition).
- `s_valid` is high for exactly 2 cycles per attempt (PRESENT, EVAL).
- Verdict sampling: `L0`/`L1` are sampled at the rising edge that ends EVAL.
  - `open` rises on the next cycle.
  - `fail_cnt` updates on that same edge.
- Lockout: `alarm` is high for exactly `LOCKOUT_CYC` cycles.
- All outputs are registered. No combinational path runs from `L0`/`L1` or `key_in` to any output.

## Test plan
- Accept: `key_in`=1110, clean ENTER pulse, checker drives `L1`=1/`L0`=0 → `S`=1110 one cycle after `press`, `s_valid` high for 2 cycles, then `open`=1 and `fail_cnt`=0. A second ENTER gives `open`=0 and `S`=0000.
- Reject then lockout (`MAX_FAIL`=3, `LOCKOUT_CYC`=16): three entries of `key_in`=1100 with `L0`=1 → `fail_cnt` goes 1,2,3. `alarm`=1 for 16 cycles, during which an ENTER pulse is ignored (no `s_valid`). Afterwards state is IDLE with `fail_cnt`=0.
- Bounce: `enter_in` toggles every cycle for 10 cycles then holds 1 → exactly one `press`, one attempt, one 2-cycle `s_valid`. A 3-cycle glitch (`DEBOUNCE_CYC`=4) → no `press`.
- Ambiguous verdict: `L0`=`L1`=1 in EVAL → counted as failure (`fail_cnt`+1), `open` stays 0. Two failures followed by an accept → `fail_cnt` returns to 0.
- Reset mid-operation: assert `rst_n`=0 during OPEN, then again during LOCKOUT → all outputs at reset values in the same cycle, no residual `alarm` or `open` after release.
- Key change after latch: `key_in` changes from 1110 to 0000 during PRESENT/EVAL → `S` stays 1110 until the next accepted `press` in IDLE.
